addsub_byte_seq: RTL

- Multi-cycle controller that performs a 32-bit add or subtract using one shared 8-bit carry-lookahead slice.
- The slice is instantiated outside this block and is purely combinational.
- The controller feeds it one byte per cycle, least-significant byte first.
- It forms the inter-byte carry from the slice's group propagate and generate outputs, accumulates the result, and reports carry-out and signed overflow. This trades latency for area in the simple ALU.

---
 rtl/addsub_byte_seq_if.sv | 25 ++
 rtl/addsub_byte_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/addsub_byte_seq_if.sv
// Request/response bundle for the byte-serial add/subtract controller.
// The master issues operations; the slave (the controller) reports status and results.
interface addsub_byte_seq_if #(
    parameter int unsigned NBYTES = 4
);
    logic                  start;
    logic                  op_sub;
    logic [8*NBYTES-1:0]   data_a;
    logic [8*NBYTES-1:0]   data_b;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   result;
    logic                  carry_out;
    logic                  overflow;

    modport master (
        output start, op_sub, data_a, data_b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op_sub, data_a, data_b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/addsub_byte_seq.sv
// Byte-serial 32-bit add/subtract controller driving an external 8-bit carry-lookahead slice,
// one byte per cycle LSB first; the inter-byte carry is rebuilt from group propagate/generate.
module addsub_byte_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic               clock,
    input  logic               reset,
    addsub_byte_seq_if.slave   bus,
    output logic [7:0]         sl_in1,
    output logic [7:0]         sl_in2,
    output logic               sl_cin,
    input  logic [7:0]         sl_sum,
    input  logic               sl_pout,
    input  logic               sl_gout,
    input  logic               sl_ovf
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [W-1:0]      result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              busy, done;
    logic              byte_carry;

    // OR-based group propagate is safe here: any generating bit also propagates.
    assign byte_carry = sl_gout | (sl_pout & carry_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;
        sl_in1   = 8'h00;
        sl_in2   = 8'h00;
        sl_cin   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.data_a;
                    b_d     = bus.op_sub ? ~bus.data_b : bus.data_b;
                    carry_d = bus.op_sub;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy                = 1'b1;
                sl_in1              = a_q[8*idx_q +: 8];
                sl_in2              = b_q[8*idx_q +: 8];
                sl_cin              = carry_q;
                acc_d[8*idx_q +: 8] = sl_sum;
                carry_d             = byte_carry;
                idx_d               = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    // Publish with the final byte merged so no partial result is ever visible.
                    result_d = acc_d;
                    cout_d   = byte_carry;
                    ovf_d    = sl_ovf;
                    state_d  = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = result_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;

endmodule
